// File: rtl/vga_stream_pkg.sv
// vga_stream_pkg: shared types, component indices and scaling helper for the VGA stream display
package vga_stream_pkg;

    typedef enum logic [1:0] {
        TM_STREAM = 2'd0,
        TM_BARS   = 2'd1,
        TM_CHECK  = 2'd2,
        TM_RAMP   = 2'd3
    } test_mode_t;

    typedef enum logic [1:0] {
        SEEK       = 2'd0,
        WAIT_FRAME = 2'd1,
        DISPLAY    = 2'd2
    } state_t;

    localparam int COMP_R = 0;
    localparam int COMP_G = 1;
    localparam int COMP_B = 2;

    // floor(num/den) clipped to steps-1, built from comparisons against constant multiples of den
    function automatic logic [31:0] scaled_index(
        input logic [31:0] num,
        input logic [31:0] den,
        input int          steps
    );
        logic [31:0] idx;
        idx = '0;
        for (int k = 1; k < steps; k++)
            if (num >= 32'(k) * den) idx = idx + 32'd1;
        return idx;
    endfunction

endpackage

// File: rtl/vga_stream_display_timing.sv
// vga_timing_gen: free-running H/V raster counters with blanking, raw sync and frame strobes
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int HW       = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
    parameter int VW       = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic          iVGA_CLK,
    input  logic          iRST_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_blank,
    output logic          v_blank,
    output logic          hs_on,
    output logic          vs_on,
    output logic          first_px,
    output logic          last_px,
    output logic          frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int VS_BEG  = V_ACTIVE + V_FRONT;

    logic [31:0] hx;
    logic [31:0] vx;
    logic        h_end;
    logic        v_end;

    assign hx        = 32'(h_cnt);
    assign vx        = 32'(v_cnt);
    assign h_end     = hx == H_TOTAL - 1;
    assign v_end     = vx == V_TOTAL - 1;
    assign h_blank   = hx >= H_ACTIVE;
    assign v_blank   = vx >= V_ACTIVE;
    assign hs_on     = (hx >= HS_BEG) && (hx < HS_BEG + H_SYNC);
    assign vs_on     = (vx >= VS_BEG) && (vx < VS_BEG + V_SYNC);
    assign first_px  = (hx == 0) && (vx == 0);
    assign last_px   = (hx == H_ACTIVE - 1) && (vx == V_ACTIVE - 1);
    assign frame_end = h_end && v_end;

    // Advance the raster position, wrapping at the end of each line and frame
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + HW'(1);
            if (h_end) v_cnt <= v_end ? '0 : v_cnt + VW'(1);
        end
    end

endmodule

// File: rtl/vga_stream_display.sv
// vga_stream_display: VGA output stage aligning a sof-marked pixel stream to internal timing, with test patterns
module vga_stream_display
    import vga_stream_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int COMP_W     = 8,
    parameter int COLOR_RES  = 4,
    parameter int NUM_BARS   = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  iVGA_CLK,
    input  logic                  iRST_n,
    input  logic [1:0]            test_mode,
    input  logic                  clr_stats,
    input  logic                  pixel_valid,
    input  logic                  pixel_sof,
    input  logic [3*COMP_W-1:0]   pixel_data,
    output logic                  pixel_ready,
    output logic                  h_blank,
    output logic                  v_blank,
    output logic                  frame_active,
    output logic [CNT_W-1:0]      underflow_cnt,
    output logic [CNT_W-1:0]      sof_err_cnt,
    output logic                  underflow_flag,
    output logic                  oHS,
    output logic                  oVS,
    output logic                  oDE,
    output logic [COLOR_RES-1:0]  oVGA_R,
    output logic [COLOR_RES-1:0]  oVGA_G,
    output logic [COLOR_RES-1:0]  oVGA_B
);

    localparam int   H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int   HW      = $clog2(H_TOTAL);
    localparam int   VW      = $clog2(V_TOTAL);
    localparam logic HS_ON   = HS_POL != 0;
    localparam logic VS_ON   = VS_POL != 0;

    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic                 hs_on;
    logic                 vs_on;
    logic                 first_px;
    logic                 last_px;
    logic                 frame_end;
    logic                 active;
    logic                 mid_sof;
    logic                 stream_mode;
    test_mode_t           tm;
    state_t               state;
    state_t               state_nx;
    logic                 show;
    logic                 starve;
    logic                 sof_err;
    logic [2:0]           bar_idx;
    logic [COLOR_RES-1:0] ramp;
    logic                 chk;
    logic [COLOR_RES-1:0] str_r;
    logic [COLOR_RES-1:0] str_g;
    logic [COLOR_RES-1:0] str_b;
    logic [COLOR_RES-1:0] pat_r;
    logic [COLOR_RES-1:0] pat_g;
    logic [COLOR_RES-1:0] pat_b;
    logic                 unused_bits;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .iVGA_CLK  (iVGA_CLK),
        .iRST_n    (iRST_n),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .h_blank   (h_blank),
        .v_blank   (v_blank),
        .hs_on     (hs_on),
        .vs_on     (vs_on),
        .first_px  (first_px),
        .last_px   (last_px),
        .frame_end (frame_end)
    );

    assign active       = ~h_blank & ~v_blank;
    assign tm           = test_mode_t'(test_mode);
    assign stream_mode  = tm == TM_STREAM;
    assign mid_sof      = pixel_sof & ~first_px;
    assign frame_active = state == DISPLAY;
    assign unused_bits  = ^pixel_data;

    // Hold the frame-alignment state
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state <= SEEK;
        else         state <= state_nx;
    end

    // Frame alignment: drop stale pixels, wait for the raster origin, then consume one pixel per active clock
    always_comb begin
        state_nx    = state;
        pixel_ready = 1'b0;
        show        = 1'b0;
        starve      = 1'b0;
        sof_err     = 1'b0;
        if (!stream_mode) state_nx = SEEK;
        else case (state)
            SEEK: begin
                pixel_ready = pixel_valid & ~pixel_sof;
                if (pixel_valid & pixel_sof) state_nx = WAIT_FRAME;
            end
            WAIT_FRAME: if (frame_end) state_nx = DISPLAY;
            DISPLAY: begin
                pixel_ready = active & ~mid_sof;
                show        = active & pixel_valid & ~mid_sof;
                starve      = active & ~pixel_valid;
                sof_err     = active & pixel_valid & mid_sof;
                if (sof_err | last_px) state_nx = SEEK;
            end
            default: state_nx = SEEK;
        endcase
    end

    assign bar_idx = 3'(scaled_index(32'(h_cnt) * NUM_BARS, H_ACTIVE, NUM_BARS));
    assign ramp    = COLOR_RES'(scaled_index(32'(h_cnt) << COLOR_RES, H_ACTIVE, 2 ** COLOR_RES));
    assign chk     = h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2];
    assign str_r   = show ? pixel_data[COMP_R*COMP_W + COMP_W - 1 -: COLOR_RES] : '0;
    assign str_g   = show ? pixel_data[COMP_G*COMP_W + COMP_W - 1 -: COLOR_RES] : '0;
    assign str_b   = show ? pixel_data[COMP_B*COMP_W + COMP_W - 1 -: COLOR_RES] : '0;

    // Pick the colour for the current raster position from the stream or a test pattern
    always_comb begin
        pat_r = tm == TM_BARS  ? {COLOR_RES{bar_idx[0]}} :
                tm == TM_CHECK ? {COLOR_RES{chk}} :
                tm == TM_RAMP  ? ramp : str_r;
        pat_g = tm == TM_BARS  ? {COLOR_RES{bar_idx[1]}} :
                tm == TM_CHECK ? {COLOR_RES{chk}} :
                tm == TM_RAMP  ? ramp : str_g;
        pat_b = tm == TM_BARS  ? {COLOR_RES{bar_idx[2]}} :
                tm == TM_CHECK ? {COLOR_RES{chk}} :
                tm == TM_RAMP  ? ramp : str_b;
    end

    // Register sync, enable and colour together so they stay aligned at the pins
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oHS    <= ~HS_ON;
            oVS    <= ~VS_ON;
            oDE    <= 1'b0;
            oVGA_R <= '0;
            oVGA_G <= '0;
            oVGA_B <= '0;
        end else begin
            oHS    <= hs_on ? HS_ON : ~HS_ON;
            oVS    <= vs_on ? VS_ON : ~VS_ON;
            oDE    <= active;
            oVGA_R <= active ? pat_r : '0;
            oVGA_G <= active ? pat_g : '0;
            oVGA_B <= active ? pat_b : '0;
        end
    end

    // Saturating statistics and sticky underflow flag; a clear wins over a same-cycle increment
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            underflow_cnt  <= '0;
            sof_err_cnt    <= '0;
            underflow_flag <= 1'b0;
        end else if (clr_stats) begin
            underflow_cnt  <= '0;
            sof_err_cnt    <= '0;
            underflow_flag <= 1'b0;
        end else begin
            if (starve && !(&underflow_cnt)) underflow_cnt <= underflow_cnt + CNT_W'(1);
            if (sof_err && !(&sof_err_cnt)) sof_err_cnt <= sof_err_cnt + CNT_W'(1);
            if (starve) underflow_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_stream_display.sv
// tb_vga_stream_display: directed frame-by-frame scoreboard bench for vga_stream_display
module tb_vga_stream_display;

    localparam logic [23:0] D1    = 24'h0000A5;
    localparam logic [23:0] D2    = 24'hF03CA5;
    localparam logic [23:0] D3    = 24'h123456;
    localparam logic [23:0] D4    = 24'h00C35A;
    localparam logic [23:0] D5    = 24'h9E7D21;
    localparam logic [23:0] STALE = 24'hFFFFFF;

    logic        iVGA_CLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic [1:0]  test_mode;
    logic        clr_stats;
    logic        pixel_valid;
    logic        pixel_sof;
    logic [23:0] pixel_data;
    logic        pixel_ready;
    logic        h_blank;
    logic        v_blank;
    logic        frame_active;
    logic [15:0] underflow_cnt;
    logic [15:0] sof_err_cnt;
    logic        underflow_flag;
    logic        oHS;
    logic        oVS;
    logic        oDE;
    logic [3:0]  oVGA_R;
    logic [3:0]  oVGA_G;
    logic [3:0]  oVGA_B;

    int checks = 0;
    int errors = 0;
    logic [14:0] sb[$];

    always #5 iVGA_CLK = ~iVGA_CLK;

    vga_stream_display #(
        .H_ACTIVE   (8),
        .H_FRONT    (2),
        .H_SYNC     (2),
        .H_BACK     (2),
        .V_ACTIVE   (4),
        .V_FRONT    (1),
        .V_SYNC     (1),
        .V_BACK     (1),
        .COLOR_RES  (4),
        .CHECK_LOG2 (1)
    ) dut (
        .iVGA_CLK       (iVGA_CLK),
        .iRST_n         (iRST_n),
        .test_mode      (test_mode),
        .clr_stats      (clr_stats),
        .pixel_valid    (pixel_valid),
        .pixel_sof      (pixel_sof),
        .pixel_data     (pixel_data),
        .pixel_ready    (pixel_ready),
        .h_blank        (h_blank),
        .v_blank        (v_blank),
        .frame_active   (frame_active),
        .underflow_cnt  (underflow_cnt),
        .sof_err_cnt    (sof_err_cnt),
        .underflow_flag (underflow_flag),
        .oHS            (oHS),
        .oVS            (oVS),
        .oDE            (oDE),
        .oVGA_R         (oVGA_R),
        .oVGA_G         (oVGA_G),
        .oVGA_B         (oVGA_B)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] top12(input logic [23:0] d);
        return {d[7:4], d[15:12], d[23:20]};
    endfunction

    // One raster clock at position p: drive, check combinational outputs, queue and retire the registered video
    task automatic tick(input int p, input logic vld, input logic sof, input logic [23:0] dat,
                        input logic clr, input logic rdy, input logic fa, input logic [11:0] rgb);
        int h;
        int v;
        logic act;
        logic [14:0] got;
        h = p % 14;
        v = p / 14;
        act = (h < 8) && (v < 4);
        pixel_valid = vld;
        pixel_sof = sof;
        pixel_data = dat;
        clr_stats = clr;
        #1;
        chk("pixel_ready", 32'(pixel_ready), 32'(rdy));
        chk("frame_active", 32'(frame_active), 32'(fa));
        chk("h_blank", 32'(h_blank), 32'(h >= 8));
        chk("v_blank", 32'(v_blank), 32'(v >= 4));
        sb.push_back({act, !(h == 10 || h == 11), v != 5, act ? rgb : 12'h000});
        @(posedge iVGA_CLK);
        #1;
        got = {oDE, oHS, oVS, oVGA_R, oVGA_G, oVGA_B};
        chk("video_de_hs_vs_rgb", 32'(got), 32'(sb.pop_front()));
    endtask

    // One full 14x7 frame starting at raster origin, behaviour chosen by scenario sc
    task automatic run_frame(input int sc);
        for (int p = 0; p < 98; p++) begin
            int h;
            int v;
            logic act, inf, vld, sof, clr, rdy, fa;
            logic [23:0] dat, cur, nxt;
            logic [11:0] rgb;
            h = p % 14;
            v = p / 14;
            act = (h < 8) && (v < 4);
            inf = (v < 3) || (v == 3 && h <= 7);
            vld = 1'b0; sof = 1'b0; clr = 1'b0; rdy = 1'b0; fa = 1'b0;
            dat = '0; rgb = '0;
            cur = sc == 1 ? D1 : sc == 2 ? D2 : sc == 4 ? D4 : D5;
            nxt = sc == 1 ? D2 : sc == 2 ? D3 : D5;
            if (sc == 2 && p == 56) begin
                chk("underflow_cnt_after_stall", 32'(underflow_cnt), 32'd3);
                chk("underflow_flag_after_stall", 32'(underflow_flag), 32'd1);
                chk("sof_err_cnt_no_err", 32'(sof_err_cnt), 32'd0);
            end
            if (sc == 2 && p == 71) begin
                chk("underflow_cnt_cleared", 32'(underflow_cnt), 32'd0);
                chk("underflow_flag_cleared", 32'(underflow_flag), 32'd0);
            end
            if (sc == 3 && p == 56) begin
                chk("sof_err_cnt_after_abort", 32'(sof_err_cnt), 32'd1);
                chk("underflow_cnt_after_abort", 32'(underflow_cnt), 32'd0);
            end
            case (sc)
                0: if (v >= 4) begin vld = 1'b1; sof = 1'b1; dat = D1; end
                1, 2, 4, 5: begin
                    if (inf) begin
                        fa = 1'b1; vld = 1'b1; sof = p == 0; dat = cur; rdy = act; rgb = top12(cur);
                        if (sc == 2 && v == 1 && h >= 2 && h <= 4) begin
                            vld = 1'b0; rgb = 12'h000;
                        end
                    end else if (v >= 4 && sc != 5) begin
                        if (sc == 4 && v == 4 && h < 2) begin
                            vld = 1'b1; dat = STALE; rdy = 1'b1;
                        end else begin
                            vld = 1'b1; sof = 1'b1; dat = nxt;
                        end
                    end
                    if (sc == 2 && p == 70) clr = 1'b1;
                end
                3: begin
                    if (p < 18) begin
                        fa = 1'b1; vld = 1'b1; sof = p == 0; dat = D3; rdy = act; rgb = top12(D3);
                    end else begin
                        fa = p == 18; vld = 1'b1; sof = 1'b1; dat = D4;
                    end
                end
                6: begin
                    vld = 1'b1; sof = 1'b1; dat = D1;
                    rgb = {h[0] ? 4'hF : 4'h0, h[1] ? 4'hF : 4'h0, h[2] ? 4'hF : 4'h0};
                end
                7: begin
                    vld = 1'b1; sof = 1'b1; dat = D1;
                    rgb = (h[1] ^ v[1]) ? 12'hFFF : 12'h000;
                end
                default: begin
                    vld = 1'b1; sof = 1'b1; dat = D1;
                    rgb = {3{4'(2 * h)}};
                end
            endcase
            tick(p, vld, sof, dat, clr, rdy, fa, rgb);
        end
    endtask

    initial begin
        test_mode = 2'd0;
        clr_stats = 1'b0;
        pixel_valid = 1'b0;
        pixel_sof = 1'b0;
        pixel_data = '0;
        repeat (2) @(posedge iVGA_CLK);
        #1;
        chk("reset_oHS", 32'(oHS), 32'd1);
        chk("reset_oVS", 32'(oVS), 32'd1);
        chk("reset_oDE", 32'(oDE), 32'd0);
        chk("reset_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'd0);
        chk("reset_ready", 32'(pixel_ready), 32'd0);
        chk("reset_frame_active", 32'(frame_active), 32'd0);
        chk("reset_underflow_cnt", 32'(underflow_cnt), 32'd0);
        chk("reset_sof_err_cnt", 32'(sof_err_cnt), 32'd0);
        chk("reset_underflow_flag", 32'(underflow_flag), 32'd0);
        iRST_n = 1'b1;
        run_frame(0);
        chk("idle_underflow_cnt", 32'(underflow_cnt), 32'd0);
        run_frame(1);
        run_frame(2);
        run_frame(3);
        run_frame(4);
        run_frame(5);
        test_mode = 2'd1;
        run_frame(6);
        test_mode = 2'd2;
        run_frame(7);
        test_mode = 2'd3;
        run_frame(8);
        pixel_valid = 1'b0;
        pixel_sof = 1'b0;
        test_mode = 2'd0;
        chk("patterns_underflow_cnt", 32'(underflow_cnt), 32'd0);
        chk("patterns_sof_err_cnt", 32'(sof_err_cnt), 32'd1);
        repeat (3) @(posedge iVGA_CLK);
        #2;
        chk("pre_reset_oDE", 32'(oDE), 32'd1);
        iRST_n = 1'b0;
        #1;
        chk("midreset_oHS", 32'(oHS), 32'd1);
        chk("midreset_oVS", 32'(oVS), 32'd1);
        chk("midreset_oDE", 32'(oDE), 32'd0);
        chk("midreset_rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'd0);
        chk("midreset_sof_err_cnt", 32'(sof_err_cnt), 32'd0);
        chk("midreset_frame_active", 32'(frame_active), 32'd0);
        chk("midreset_h_blank", 32'(h_blank), 32'd0);
        chk("midreset_v_blank", 32'(v_blank), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_stream_display.md
Name: vga_stream_display

Overview:
- Parametrised successor to the VGA output controller.
- Generates VGA timing internally with its own H/V counters and accepts a valid/ready pixel stream that carries a start-of-frame marker.
- Aligns frames to sof, counts underflows and mis-aligned frames, and replaces the single fixed pattern with selectable test patterns.
- Sits between the image pipeline (IPU) and the VGA DAC pins; also exports blanking to the MCL.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, H front porch (clocks)
- H_SYNC, 96, H sync pulse (clocks)
- H_BACK, 48, H back porch (clocks)
- V_ACTIVE, 480, active lines
- V_FRONT, 10, V front porch (lines)
- V_SYNC, 2, V sync pulse (lines)
- V_BACK, 33, V back porch (lines)
- HS_POL, 0, HS active level (0 = active-low)
- VS_POL, 0, VS active level (0 = active-low)
- COMP_W, 8, input bits per colour component
- COLOR_RES, 4, output bits per colour (COLOR_RES ≤ COMP_W)
- NUM_BARS, 8, colour bars in bar pattern (power of 2, ≤ 8)
- CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels
- CNT_W, 16, width of the statistics counters

Ports:
- iVGA_CLK, in, 1, pixel clock; sole clock
- iRST_n, in, 1, asynchronous active-low reset
- test_mode, in, 2, 0 = stream, 1 = colour bars, 2 = checker, 3 = grey ramp
- clr_stats, in, 1, synchronous clear of the statistics counters and sticky flags
- pixel_valid, in, 1, stream valid
- pixel_sof, in, 1, marks the first pixel of a frame
- pixel_data, in, 3*COMP_W, {B,G,R}; R in the LSBs
- pixel_ready, out, 1, stream ready
- h_blank, out, 1, h_cnt ≥ H_ACTIVE (combinational from counters)
- v_blank, out, 1, v_cnt ≥ V_ACTIVE (combinational from counters)
- frame_active, out, 1, FSM is in DISPLAY
- underflow_cnt, out, CNT_W, saturating count of starved active pixels
- sof_err_cnt, out, CNT_W, saturating count of mid-frame sof aborts
- underflow_flag, out, 1, sticky underflow indicator
- oHS, out, 1, horizontal sync
- oVS, out, 1, vertical sync
- oDE, out, 1, registered active-video indicator
- oVGA_R, out, COLOR_RES, red output
- oVGA_G, out, COLOR_RES, green output
- oVGA_B, out, COLOR_RES, blue output

Behaviour:
- Clock and reset: single clock iVGA_CLK; iRST_n is an asynchronous, active-low reset.
- Reset values:
  - counters 0; FSM = SEEK
  - oHS = ~HS_POL, oVS = ~VS_POL
  - oDE, RGB, pixel_ready, stats and flags all 0
- Timing:
  - H_TOTAL = sum of the four H params; V_TOTAL likewise.
  - Each line is ordered active, front porch, sync, back porch.
  - h_cnt wraps at H_TOTAL-1; v_cnt increments on that wrap and wraps at V_TOTAL-1.
  - active = !h_blank & !v_blank.
- Outputs (all registered, latency 1):
  - The values computed at (h_cnt, v_cnt) appear on oHS/oVS/oDE/RGB the next clock, so sync and colour stay aligned.
  - RGB = top COLOR_RES bits of each component.
  - RGB is 0 whenever !active.
- FSM:
  - SEEK: pixel_ready = pixel_valid & !pixel_sof & (test_mode == 0), which drops stale pixels. pixel_valid & pixel_sof & test_mode == 0 -> WAIT_FRAME.
  - WAIT_FRAME: pixel_ready = 0. At (H_TOTAL-1, V_TOTAL-1) -> DISPLAY.
  - DISPLAY: pixel_ready = active & !(pixel_sof & not at (0,0)).
    - Handshake: valid & ready -> the pixel is displayed.
    - active & !pixel_valid -> black pixel, underflow_cnt+1 (saturating), underflow_flag set. The FSM stays in DISPLAY.
    - pixel_valid & pixel_sof at an active position other than (0,0) -> pixel not consumed, black pixel, sof_err_cnt+1, -> SEEK.
    - Last active pixel (H_ACTIVE-1, V_ACTIVE-1) -> SEEK. The next frame therefore needs a fresh sof during blanking.
  - Mid-frame sof at (0,0) on entry is the expected case, not an error.
  - test_mode ≠ 0: the FSM is forced to SEEK and pixel_ready = 0. On return to 0 the stream re-aligns on the next sof.
  - Outside DISPLAY, active pixels in stream mode are output black and are not counted as underflow.
- Patterns (x = h_cnt, y = v_cnt):
  - Bars: idx = (x*NUM_BARS)/H_ACTIVE. R = idx[0], G = idx[1], B = idx[2]; each set bit gives an all-ones component.
  - Checker: white if x[CHECK_LOG2] ^ y[CHECK_LOG2], else black.
  - Ramp: each component = (x << COLOR_RES)/H_ACTIVE. Use constant multipliers; no runtime divide.
- Simultaneous events: clr_stats has priority over an increment in the same cycle.
- Counters hold at all-ones when saturated.
- Reset asserted mid-frame: immediate return to reset values; resynchronisation only through a new sof.

Decomposition:
- Package vga_stream_pkg:
  - test_mode enum (TM_STREAM, TM_BARS, TM_CHECK, TM_RAMP)
  - FSM state enum (SEEK, WAIT_FRAME, DISPLAY)
  - component index constants
- Sub-module vga_timing_gen: h/v counters, blanking, raw sync, and first/last-pixel strobes.
- Handshake, FSM, patterns and the output register stay in the top level.

Test Plan (sim params: H 8/2/2/2, H_TOTAL 14; V 4/1/1/1, V_TOTAL 7; COLOR_RES 4; CHECK_LOG2 1):
- Reset release, test_mode = 0, no valid -> oHS = oVS = 1 when idle. oHS low for 2 clocks starting at h_cnt = 10, plus 1-cycle latency. oVS low on line 5. RGB 0; underflow_cnt stays 0.
- Continuous source, sof on first pixel, pixel_data = {B=0x00, G=0x00, R=0xA5} -> one full frame of oVGA_R = 0xA, oDE high for 32 clocks. frame_active drops after pixel (7,3).
- Source stalls valid for 3 clocks mid-frame -> 3 black pixels, underflow_cnt = 3, underflow_flag = 1. Frame completes; clr_stats -> both back to 0.
- sof asserted at (4,1) -> pixel_ready low at that cycle, sof_err_cnt = 1. Display resumes at the next frame's (0,0) with that sof pixel.
- Two stale non-sof pixels queued before sof in SEEK -> both dropped (ready high for 2 clocks); the sof pixel is shown at (0,0).
- test_mode = 1 -> pixel_ready = 0; bars show R/G/B = F/0/0 at x = 1, 0/F/0 at x = 2, F/F/F at x = 7. test_mode = 2 -> oVGA_R toggles every 2 pixels, with phase inverting every 2 lines.
